census_transform: RTL and testbench

Streaming census-transform generator: the producer of the 72-bit bit vectors (`bitvec` plus `bitvec_val`) that feed the correlation stage. The block takes a raster-order 8-bit grayscale pixel stream from one camera. Each bit of the output vector compares one pixel of a 9-column × 8-row window against the window's reference pixel. One instance runs per camera (left, right), and the outputs connect directly to the correlator's `left_bitvec` / `right_bitvec` and `bitvec_val` inputs.

---
 rtl/census_transform.sv | 146 ++++++++++++++
 tb/tb_census_transform.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/census_transform.sv
// census_transform
//   Streaming 9x8 census-transform generator for one camera. Accepts a
//   raster-order 8-bit pixel stream and emits, for every pixel whose window
//   lies fully inside the frame, a 72-bit vector of "neighbour < reference"
//   bits. Pipeline: line-buffer read / counter capture, window shift,
//   compare + output register (pixel sampled at edge k -> output at k+2).
//
// Ports
//   clk, reset   : clock, asynchronous active-high reset
//   pixel_in     : 8-bit unsigned grayscale pixel
//   pixel_val    : pixel_in valid this cycle
//   pixel_sof    : start of frame, qualified by pixel_val; marks pixel (0,0)
//   bitvec       : census vector; bit 71 = top-left, bit 31 = reference
//   bitvec_val   : one-cycle pulse per produced vector
//   pixel_x/y    : image coordinates of the window reference pixel

// One window row: 9 neighbours against the reference, MSB = left column.
module census_row (
  input  logic [8:0][7:0] pix,
  input  logic [7:0]      ref_pix,
  output logic [8:0]      bits
);
  for (genvar c = 0; c < 9; c++) begin : g_col
    assign bits[8-c] = (pix[c] < ref_pix);
  end
endmodule

module census_transform #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_val,
  input  logic        pixel_sof,
  output logic [71:0] bitvec,
  output logic        bitvec_val,
  output logic [9:0]  pixel_x,
  output logic [8:0]  pixel_y
);
  localparam int XW     = $clog2(IMG_WIDTH);
  localparam int YW     = $clog2(IMG_HEIGHT);
  localparam int ROWS   = 8;
  localparam int COLS   = 9;
  localparam int LB     = ROWS - 1;
  localparam int STAGES = 1;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          ok;   // window fully inside the frame
  } pos_t;

  logic [XW-1:0] x_cnt, cur_x;
  logic [YW-1:0] y_cnt, cur_y;
  logic          last_x;
  logic [2:0]    wptr;   // slot holding the oldest row (y-7); overwritten by row y
  logic [7:0]    lbuf [LB][IMG_WIDTH];
  logic [ROWS-1:0][7:0]           s1_col;  // [0] = row y-7 ... [7] = row y
  logic [ROWS-1:0][COLS-1:0][7:0] win;     // win[r][c], r=0 top, c=0 left
  pos_t          s1_pos, s2_pos;
  logic [STAGES:0] vld_pipe;
  logic [71:0]   census;

  // sof overrides the counters for the pixel it qualifies
  assign cur_x  = pixel_sof ? '0 : x_cnt;
  assign cur_y  = pixel_sof ? '0 : y_cnt;
  assign last_x = (cur_x == XW'(IMG_WIDTH - 1));

  function automatic logic [2:0] slot(input logic [2:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= LB) s = s - LB;
    return 3'(s);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
      wptr  <= '0;
    end else if (pixel_val) begin
      if (last_x) begin
        x_cnt <= '0;
        y_cnt <= (cur_y == YW'(IMG_HEIGHT - 1)) ? '0 : cur_y + YW'(1);
        wptr  <= (wptr == 3'(LB - 1)) ? '0 : wptr + 3'd1;
      end else begin
        x_cnt <= cur_x + XW'(1);
        y_cnt <= cur_y;
      end
    end
  end

  // Line buffers: read all 7 stored rows at column x (old data) while the
  // current pixel replaces the oldest row at the same column.
  always_ff @(posedge clk) begin
    if (pixel_val) begin
      lbuf[wptr][cur_x] <= pixel_in;
      for (int k = 0; k < LB; k++) s1_col[k] <= lbuf[slot(wptr, k)][cur_x];
      s1_col[LB] <= pixel_in;
    end
  end

  // Window shifts left only for valid columns, so gaps leave it untouched.
  always_ff @(posedge clk) begin
    if (vld_pipe[0]) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS - 1; c++) win[r][c] <= win[r][c+1];
        win[r][COLS-1] <= s1_col[r];
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    census_row u_row (
      .pix     (win[r]),
      .ref_pix (win[4][4]),
      .bits    (census[71-9*r -: 9])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe   <= '0;
      s1_pos     <= '0;
      s2_pos     <= '0;
      bitvec     <= '0;
      bitvec_val <= 1'b0;
      pixel_x    <= '0;
      pixel_y    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], pixel_val};
      if (pixel_val)
        s1_pos <= '{x: cur_x, y: cur_y,
                    ok: (cur_x >= XW'(8)) && (cur_y >= YW'(7))};
      if (vld_pipe[0]) s2_pos <= s1_pos;
      bitvec_val <= vld_pipe[1] & s2_pos.ok;
      if (vld_pipe[1] & s2_pos.ok) begin
        bitvec  <= census;
        pixel_x <= 10'(s2_pos.x) - 10'd4;
        pixel_y <= 9'(s2_pos.y) - 9'd3;
      end
    end
  end
endmodule

// File: tb/tb_census_transform.sv
// Self-checking bench for census_transform (16x12 frames). A reference model
// stores the incoming image and computes each expected census vector from
// the pixel array directly; a monitor pops the scoreboard on every cycle.
module tb_census_transform;
  localparam int W = 16;
  localparam int H = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  pixel_in = '0;
  logic        pixel_val = 1'b0;
  logic        pixel_sof = 1'b0;
  logic [71:0] bitvec;
  logic        bitvec_val;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;

  census_transform #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_in   (pixel_in),
    .pixel_val  (pixel_val),
    .pixel_sof  (pixel_sof),
    .bitvec     (bitvec),
    .bitvec_val (bitvec_val),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [71:0] bv;
    int px;
    int py;
    int t;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  img   [H][W];
  logic [7:0]  frame [H][W];
  int          mx = 0, my = 0;
  int          n_cmp = 0, n_bad = 0;
  int          pulses = 0, first_px = -1, first_py = -1;
  logic [71:0] seen[int];
  logic [71:0] got[$];
  logic [71:0] ref_seq[$];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Census straight from the definition: window rows y-7..y, cols x-8..x.
  function automatic logic [71:0] model_census(input int x, input int y);
    logic [71:0] v;
    logic [7:0]  rp;
    v  = '0;
    rp = img[y-3][x-4];
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 9; c++)
        v[71-(r*9+c)] = (img[y-7+r][x-8+c] < rp);
    return v;
  endfunction

  task automatic idle();
    @(posedge clk); #1;
    pixel_val = 1'b0;
    pixel_sof = 1'($urandom_range(0, 1));
    pixel_in  = 8'($urandom);
  endtask

  task automatic send(input logic [7:0] p, input bit sof);
    exp_t e;
    @(posedge clk); #1;
    pixel_in  = p;
    pixel_val = 1'b1;
    pixel_sof = sof;
    if (sof) begin mx = 0; my = 0; end
    img[my][mx] = p;
    if (mx >= 8 && my >= 7) begin
      e.bv = model_census(mx, my);
      e.px = mx - 4;
      e.py = my - 3;
      e.t  = cyc + 3;
      q.push_back(e);
    end
    if (mx == W - 1) begin
      mx = 0;
      my = (my == H - 1) ? 0 : my + 1;
    end else mx = mx + 1;
  endtask

  task automatic send_frame(input bit gapped, input bit sof);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (gapped) while ($urandom_range(0, 1) == 1) idle();
        send(frame[y][x], sof && x == 0 && y == 0);
      end
  endtask

  task automatic drain();
    repeat (6) idle();
  endtask

  task automatic begin_count();
    pulses = 0; first_px = -1; first_py = -1;
    seen.delete();
    got.delete();
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) frame[y][x] = v;
  endtask

  task automatic fill_rand();
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) frame[y][x] = 8'($urandom);
  endtask

  task automatic check_frame_stats(input string tag);
    check({tag, "_pulses"}, 72'(pulses), 72'd40);
    check({tag, "_first_px"}, 72'(first_px), 72'd4);
    check({tag, "_first_py"}, 72'(first_py), 72'd4);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bitvec"}, bitvec, 72'd0);
    check({tag, "_val"}, 72'(bitvec_val), 72'd0);
    check({tag, "_px"}, 72'(pixel_x), 72'd0);
    check({tag, "_py"}, 72'(pixel_y), 72'd0);
  endtask

  // Monitor: a pulse must appear exactly on the cycle the model scheduled.
  exp_t me;
  always @(negedge clk) begin
    if (!reset) begin
      if (q.size() > 0 && q[0].t <= cyc) begin
        me = q.pop_front();
        if (!bitvec_val) begin
          n_cmp++; n_bad++;
          $display("FAIL missing_pulse: no bitvec_val at cycle %0d, expected ref (%0d,%0d)",
                   cyc, me.px, me.py);
        end else begin
          check("bitvec", bitvec, me.bv);
          check("pixel_x", 72'(pixel_x), 72'(me.px));
          check("pixel_y", 72'(pixel_y), 72'(me.py));
        end
      end else if (bitvec_val) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_pulse: bitvec_val at cycle %0d ref (%0d,%0d), expected none",
                 cyc, pixel_x, pixel_y);
      end
      if (bitvec_val) begin
        pulses++;
        if (first_px < 0) begin first_px = int'(pixel_x); first_py = int'(pixel_y); end
        seen[int'(pixel_y) * 64 + int'(pixel_x)] = bitvec;
        got.push_back(bitvec);
      end
    end
  end

  initial begin
    int i;
    bit same;
    #2 reset = 1'b1;
    #1 check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // uniform frame: 40 all-zero vectors, first at ref (4,4)
    fill_const(8'h80);
    begin_count();
    send_frame(0, 1);
    drain();
    check_frame_stats("uniform");

    // bright reference at (6,6)
    fill_const(8'h10);
    frame[6][6] = 8'hFF;
    begin_count();
    send_frame(0, 1);
    drain();
    check("bright_ref", seen[6*64+6], 72'hFF_FFFF_FFFF_7FFF_FFFF);

    // dark top-left pixel
    fill_const(8'h50);
    frame[0][0] = 8'h00;
    begin_count();
    send_frame(0, 1);
    drain();
    check("dark_topleft", seen[4*64+4], 72'h80_0000_0000_0000_0000);

    // random frame back-to-back, then the same frame with gaps
    fill_rand();
    begin_count();
    send_frame(0, 1);
    drain();
    ref_seq = got;
    begin_count();
    send_frame(1, 1);
    drain();
    same = (got.size() == ref_seq.size());
    if (same) foreach (got[k]) if (got[k] !== ref_seq[k]) same = 0;
    check("gapped_matches_b2b", 72'(same), 72'd1);
    check("gapped_pulses", 72'(got.size()), 72'd40);

    // resync: sof arrives at pixel (5,3) of a partial frame
    fill_rand();
    begin_count();
    for (i = 0; i < 3 * W + 5; i++) send(frame[i / W][i % W], i == 0);
    fill_rand();
    send_frame(0, 1);
    drain();
    check_frame_stats("resync");

    // reset mid-stream, then a frame without sof
    fill_rand();
    for (i = 0; i < 150; i++) send(frame[i / W][i % W], i == 0);
    @(posedge clk); #1;
    pixel_val = 1'b0;
    reset = 1'b1;
    q.delete();
    #1 check_outputs_zero("midreset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    mx = 0; my = 0;
    fill_rand();
    begin_count();
    send_frame(0, 0);
    drain();
    check_frame_stats("post_reset");

    check("queue_drained", 72'(q.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
